normalizer_rounder: RTL and testbench
=====================================

# normalizer_rounder

- Multi-cycle post-arithmetic stage; the inverse of operand extension.
- Accepts an extended mantissa (carry, hidden, fraction, guard and round bits, plus a sticky bit) with a wide signed exponent.
- Normalizes the mantissa one bit per cycle, rounds, classifies and packs the result into a MANTIS_SIZE fraction, an EXP_SIZE exponent and a type code.
- Sits between the adder/multiplier datapath and the result packer; uses valid/ready handshakes on both sides.

## Interface

- MANTIS_SIZE, default `MANTIS_SIZE` (from configuration.v): stored fraction width.
- EXP_SIZE, default `EXP_SIZE` (from configuration.v): stored exponent width.

- clk  input  1  clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operand valid
- in_ready  output  1  block can accept an operand
- sign_in  input  1  sign
- mantis_in  input  MANTIS_SIZE+4  {carry, hidden, fraction, guard, round}
- sticky_in  input  1  OR of all bits below round
- exp_in  input  EXP_SIZE+2  two's-complement biased exponent
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- sign_out  output  1  sign, passed through
- mantis_out  output  MANTIS_SIZE  packed fraction
- exp_out  output  EXP_SIZE  packed biased exponent
- type_number  output  3  result class: 3'b001 zero, 3'b010 subnormal, 3'b011 normal, 3'b100 infinity

## Operation

FSM states: IDLE, SHIFT, ROUND, DONE.

- **IDLE**
  - in_ready=1.
  - On in_valid, capture sign, mantissa, sticky and exponent.
  - If mantis_in==0 and sticky_in==0, go to DONE with a zero result (exp_out=0, mantis_out=0, type 001).
  - Otherwise go to SHIFT.
- **SHIFT**: one action per cycle, evaluated in this priority:
  1. Carry bit set: shift right 1 and OR the shifted-out bit into sticky; exp+1.
  2. exp < -(MANTIS_SIZE+3): flush. mantissa=0, sticky |= OR(mantissa), exp=1.
  3. exp < 1: shift right 1 (sticky accumulates); exp+1.
  4. Hidden bit 0 and exp > 1: shift left 1, zero fill; exp-1.
  5. Otherwise go to ROUND.
- **ROUND**
  - lsb = bit 2, guard = bit 1, rs = bit 0 | sticky.
  - Increment at bit 2 when guard & (rs | lsb).
  - If the increment sets the carry bit, shift right 1 and exp+1 in the same cycle.
  - Classification:
    - exp >= 2^EXP_SIZE-1: infinity; exp_out all ones, mantis_out 0.
    - Hidden=1: normal; exp_out=exp.
    - Hidden=0 and fraction≠0: subnormal; exp_out=0.
    - Hidden=0 and fraction==0: zero; exp_out=0.
  - Register the outputs and go to DONE.
- **DONE**
  - out_valid=1; outputs held stable until out_ready.
  - On out_ready, return to IDLE.
- Arithmetic width: internal exponent is EXP_SIZE+2 bits signed and never wraps, because the flush bounds the right shifts.

## Timing

- Reset values:
  - in_ready=0 while rst is high, 1 in the first cycle after release.
  - out_valid=0, sign_out=0, mantis_out=0, exp_out=0, type_number=3'b000.
- Latency (acceptance edge = cycle 0):
  - Already-normalized input: out_valid from cycle 3.
  - Each shift adds 1 cycle.
  - Zero input: out_valid from cycle 1.
- One operation in flight at a time. in_ready=0 from the cycle after acceptance until the cycle after the out handshake.
- rst asserted in any state: the next state is IDLE with reset values and the in-flight operation is discarded.
- out_ready asserted while out_valid=0 is ignored.
- in_valid while in_ready=0 is ignored; the producer must hold its data.

## Configuration

- Macro: `FPA_ROUND_RNE_EN`.
- Defined: ROUND performs round-to-nearest-even as described above.
- Undefined: ROUND truncates (never increments). The state is still traversed, so latency is unchanged.

## Test plan

Parameters for all tests: MANTIS_SIZE=23, EXP_SIZE=8.

1. mantis_in=27'h2000000, exp_in=127, sticky_in=0 -> out_valid at cycle 3; mantis_out=0, exp_out=127, type 011.
2. mantis_in=27'h4000000, exp_in=127 -> one right shift; out_valid at cycle 4; exp_out=128, mantis_out=0, type 011.
3. mantis_in=27'h0000004, exp_in=127 -> 23 left shifts; out_valid at cycle 26; exp_out=104, mantis_out=0, type 011. Then mantis_in=27'h1000000, exp_in=1 -> subnormal: exp_out=0, mantis_out=23'h400000, type 010.
4. Rounding ties, both with exp_in=127:
   - mantis_in=27'h2000006 -> mantis_out=2 with the macro, 1 without.
   - mantis_in=27'h2000002 -> mantis_out=0 in both builds.
5. mantis_in=27'h3FFFFFE, exp_in=254, macro on -> rounding carry; exp_out=255, mantis_out=0, type 100.
6. Backpressure and reset:
   - Hold out_ready=0 for 5 cycles in DONE -> outputs stable and out_valid held.
   - Assert rst for 1 cycle mid-SHIFT -> next cycle out_valid=0 and in_ready=0; in_ready=1 the cycle after release; a new operand then completes correctly.

Source files
------------

// File: rtl/normalizer_rounder_if.sv
// Handshake and data bundle for the normalizer/rounder stage.
// Width defaults come from the MANTIS_SIZE / EXP_SIZE configuration macros.
`ifndef MANTIS_SIZE
`define MANTIS_SIZE 23
`endif
`ifndef EXP_SIZE
`define EXP_SIZE 8
`endif

interface normalizer_rounder_if #(
  parameter int MANTIS_SIZE = `MANTIS_SIZE,
  parameter int EXP_SIZE    = `EXP_SIZE
);
  logic                   in_valid;
  logic                   in_ready;
  logic                   sign_in;
  logic [MANTIS_SIZE+3:0] mantis_in;
  logic                   sticky_in;
  logic [EXP_SIZE+1:0]    exp_in;
  logic                   out_valid;
  logic                   out_ready;
  logic                   sign_out;
  logic [MANTIS_SIZE-1:0] mantis_out;
  logic [EXP_SIZE-1:0]    exp_out;
  logic [2:0]             type_number;

  modport master (
    output in_valid, sign_in, mantis_in, sticky_in, exp_in, out_ready,
    input  in_ready, out_valid, sign_out, mantis_out, exp_out, type_number
  );

  modport slave (
    input  in_valid, sign_in, mantis_in, sticky_in, exp_in, out_ready,
    output in_ready, out_valid, sign_out, mantis_out, exp_out, type_number
  );
endinterface

// File: rtl/normalizer_rounder.sv
// Multi-cycle normalize / round / classify / pack stage (one bit of shift per cycle).
// FPA_ROUND_RNE_EN selects round-to-nearest-even; otherwise the ROUND state truncates.
`ifndef MANTIS_SIZE
`define MANTIS_SIZE 23
`endif
`ifndef EXP_SIZE
`define EXP_SIZE 8
`endif

module normalizer_rounder #(
  parameter int MANTIS_SIZE = `MANTIS_SIZE,
  parameter int EXP_SIZE    = `EXP_SIZE
) (
  input logic                clk,
  input logic                rst,
  normalizer_rounder_if.slave io
);
  localparam int W       = MANTIS_SIZE + 4;
  localparam int XW      = EXP_SIZE + 2;
  localparam int EXP_INF = (1 << EXP_SIZE) - 1;

  localparam logic [2:0] T_ZERO = 3'b001;
  localparam logic [2:0] T_SUB  = 3'b010;
  localparam logic [2:0] T_NORM = 3'b011;
  localparam logic [2:0] T_INF  = 3'b100;

  typedef enum logic [1:0] {IDLE, SHIFT, ROUND, DONE} state_e;

  state_e                  state_q, state_d;
  logic                    rdy_q, rdy_d;
  logic                    sign_q, sign_d;
  logic [W-1:0]            man_q, man_d;
  logic                    sticky_q, sticky_d;
  logic signed [XW-1:0]    exp_q, exp_d;
  logic                    osign_q, osign_d;
  logic [MANTIS_SIZE-1:0]  omant_q, omant_d;
  logic [EXP_SIZE-1:0]     oexp_q, oexp_d;
  logic [2:0]              otype_q, otype_d;

  logic                    in_ready;
  logic                    inc;
  logic [W-1:0]            man_sum, man_r;
  logic signed [XW-1:0]    exp_r;

  assign in_ready = rdy_q & ~rst;

`ifdef FPA_ROUND_RNE_EN
  assign inc = man_q[1] & (man_q[0] | sticky_q | man_q[2]);
`else
  assign inc = 1'b0;
`endif

  // Carry is always clear on entry to ROUND, so the add cannot overflow W bits.
  always_comb begin
    man_sum = man_q + (inc ? W'(4) : W'(0));
    if (man_sum[W-1]) begin
      man_r = man_sum >> 1;
      exp_r = exp_q + XW'(1);
    end else begin
      man_r = man_sum;
      exp_r = exp_q;
    end
  end

  always_comb begin
    state_d  = state_q;
    sign_d   = sign_q;
    man_d    = man_q;
    sticky_d = sticky_q;
    exp_d    = exp_q;
    osign_d  = osign_q;
    omant_d  = omant_q;
    oexp_d   = oexp_q;
    otype_d  = otype_q;
    unique case (state_q)
      IDLE: begin
        if (io.in_valid && in_ready) begin
          sign_d   = io.sign_in;
          man_d    = io.mantis_in;
          sticky_d = io.sticky_in;
          exp_d    = signed'(io.exp_in);
          if (io.mantis_in == '0 && !io.sticky_in) begin
            state_d = DONE;
            osign_d = io.sign_in;
            omant_d = '0;
            oexp_d  = '0;
            otype_d = T_ZERO;
          end else begin
            state_d = SHIFT;
          end
        end
      end
      SHIFT: begin
        if (man_q[W-1]) begin
          man_d    = man_q >> 1;
          sticky_d = sticky_q | man_q[0];
          exp_d    = exp_q + XW'(1);
        end else if (int'(exp_q) < -(MANTIS_SIZE + 3)) begin
          // Everything would shift out anyway; collapse it into sticky in one step.
          man_d    = '0;
          sticky_d = sticky_q | (|man_q);
          exp_d    = XW'(1);
        end else if (int'(exp_q) < 1) begin
          man_d    = man_q >> 1;
          sticky_d = sticky_q | man_q[0];
          exp_d    = exp_q + XW'(1);
        end else if (!man_q[W-2] && int'(exp_q) > 1) begin
          man_d = man_q << 1;
          exp_d = exp_q - XW'(1);
        end else begin
          state_d = ROUND;
        end
      end
      ROUND: begin
        state_d = DONE;
        man_d   = man_r;
        exp_d   = exp_r;
        osign_d = sign_q;
        if (int'(exp_r) >= EXP_INF) begin
          oexp_d  = '1;
          omant_d = '0;
          otype_d = T_INF;
        end else if (man_r[W-2]) begin
          oexp_d  = exp_r[EXP_SIZE-1:0];
          omant_d = man_r[W-3:2];
          otype_d = T_NORM;
        end else begin
          oexp_d  = '0;
          omant_d = man_r[W-3:2];
          otype_d = (|man_r[W-3:2]) ? T_SUB : T_ZERO;
        end
      end
      DONE: begin
        if (io.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    rdy_d = (state_d == IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      rdy_q    <= 1'b0;
      sign_q   <= 1'b0;
      man_q    <= '0;
      sticky_q <= 1'b0;
      exp_q    <= '0;
      osign_q  <= 1'b0;
      omant_q  <= '0;
      oexp_q   <= '0;
      otype_q  <= 3'b000;
    end else begin
      state_q  <= state_d;
      rdy_q    <= rdy_d;
      sign_q   <= sign_d;
      man_q    <= man_d;
      sticky_q <= sticky_d;
      exp_q    <= exp_d;
      osign_q  <= osign_d;
      omant_q  <= omant_d;
      oexp_q   <= oexp_d;
      otype_q  <= otype_d;
    end
  end

  assign io.in_ready    = in_ready;
  assign io.out_valid   = (state_q == DONE);
  assign io.sign_out    = osign_q;
  assign io.mantis_out  = omant_q;
  assign io.exp_out     = oexp_q;
  assign io.type_number = otype_q;
endmodule

// File: tb/tb_normalizer_rounder.sv
// Directed-vector bench for normalizer_rounder (MANTIS_SIZE=23, EXP_SIZE=8).
// Rounding expectations follow FPA_ROUND_RNE_EN.
module tb_normalizer_rounder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  normalizer_rounder_if #(.MANTIS_SIZE(23), .EXP_SIZE(8)) io ();

  normalizer_rounder #(.MANTIS_SIZE(23), .EXP_SIZE(8)) dut (
    .clk (clk),
    .rst (rst),
    .io  (io.slave)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Waits for in_ready, presents one operand, returns the cycle (acceptance edge = 0)
  // at which out_valid is first seen, or -1 on timeout. Returns at a negedge.
  task automatic send(input logic s, input logic [26:0] m, input logic st,
                      input logic [9:0] e, output int lat);
    int w;
    w   = 0;
    lat = -1;
    @(negedge clk);
    while (!io.in_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (!io.in_ready) return;
    io.in_valid  = 1'b1;
    io.sign_in   = s;
    io.mantis_in = m;
    io.sticky_in = st;
    io.exp_in    = e;
    @(posedge clk);
    #1 io.in_valid = 1'b0;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (io.out_valid) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic consume();
    io.out_ready = 1'b1;
    @(posedge clk);
    #1 io.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_vec++; if (io.in_ready !== 1'b0) begin n_bad++; $display("FAIL rst_in_ready: got %b want 0", io.in_ready); end
    n_vec++; if (io.out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_out_valid: got %b want 0", io.out_valid); end
    n_vec++; if ({io.sign_out, io.mantis_out, io.exp_out, io.type_number} !== 35'd0) begin
      n_bad++; $display("FAIL rst_outputs: got s=%b m=%h e=%h t=%b want all 0", io.sign_out, io.mantis_out, io.exp_out, io.type_number);
    end
    rst = 1'b0;
    @(negedge clk);
    n_vec++; if (io.in_ready !== 1'b1) begin n_bad++; $display("FAIL rst_release_ready: got %b want 1", io.in_ready); end
  endtask

  task automatic test_normal();
    int lat;
    send(1'b1, 27'h2000000, 1'b0, 10'd127, lat);
    n_vec++; if (lat !== 3) begin n_bad++; $display("FAIL norm_latency: got %0d want 3", lat); end
    n_vec++; if ({io.sign_out, io.mantis_out, io.exp_out, io.type_number} !== {1'b1, 23'h0, 8'd127, 3'b011}) begin
      n_bad++; $display("FAIL norm_result: got s=%b m=%h e=%0d t=%b want s=1 m=0 e=127 t=011", io.sign_out, io.mantis_out, io.exp_out, io.type_number);
    end
    n_vec++; if (io.in_ready !== 1'b0) begin n_bad++; $display("FAIL norm_busy_ready: got %b want 0", io.in_ready); end
    consume();
  endtask

  task automatic test_right_shift();
    int lat;
    send(1'b0, 27'h4000000, 1'b0, 10'd127, lat);
    n_vec++; if (lat !== 4) begin n_bad++; $display("FAIL rshift_latency: got %0d want 4", lat); end
    n_vec++; if ({io.mantis_out, io.exp_out, io.type_number} !== {23'h0, 8'd128, 3'b011}) begin
      n_bad++; $display("FAIL rshift_result: got m=%h e=%0d t=%b want m=0 e=128 t=011", io.mantis_out, io.exp_out, io.type_number);
    end
    consume();
  endtask

  task automatic test_left_shift();
    int lat;
    send(1'b0, 27'h0000004, 1'b0, 10'd127, lat);
    n_vec++; if (lat !== 26) begin n_bad++; $display("FAIL lshift_latency: got %0d want 26", lat); end
    n_vec++; if ({io.mantis_out, io.exp_out, io.type_number} !== {23'h0, 8'd104, 3'b011}) begin
      n_bad++; $display("FAIL lshift_result: got m=%h e=%0d t=%b want m=0 e=104 t=011", io.mantis_out, io.exp_out, io.type_number);
    end
    consume();
    send(1'b0, 27'h1000000, 1'b0, 10'd1, lat);
    n_vec++; if (lat !== 3) begin n_bad++; $display("FAIL subn_latency: got %0d want 3", lat); end
    n_vec++; if ({io.mantis_out, io.exp_out, io.type_number} !== {23'h400000, 8'd0, 3'b010}) begin
      n_bad++; $display("FAIL subn_result: got m=%h e=%0d t=%b want m=400000 e=0 t=010", io.mantis_out, io.exp_out, io.type_number);
    end
    consume();
  endtask

  task automatic test_denorm_shift();
    int lat;
    // exp 0 forces one right shift into the subnormal range
    send(1'b0, 27'h2000000, 1'b0, 10'd0, lat);
    n_vec++; if (lat !== 4) begin n_bad++; $display("FAIL denorm_latency: got %0d want 4", lat); end
    n_vec++; if ({io.mantis_out, io.exp_out, io.type_number} !== {23'h400000, 8'd0, 3'b010}) begin
      n_bad++; $display("FAIL denorm_result: got m=%h e=%0d t=%b want m=400000 e=0 t=010", io.mantis_out, io.exp_out, io.type_number);
    end
    consume();
    // far below range: flushed to sticky, rounds to zero
    send(1'b0, 27'h2000000, 1'b0, 10'(-40), lat);
    n_vec++; if (lat !== 4) begin n_bad++; $display("FAIL flush_latency: got %0d want 4", lat); end
    n_vec++; if ({io.mantis_out, io.exp_out, io.type_number} !== {23'h0, 8'd0, 3'b001}) begin
      n_bad++; $display("FAIL flush_result: got m=%h e=%0d t=%b want m=0 e=0 t=001", io.mantis_out, io.exp_out, io.type_number);
    end
    consume();
  endtask

  task automatic test_zero_inf();
    int lat;
    send(1'b1, 27'h0, 1'b0, 10'd77, lat);
    n_vec++; if (lat !== 1) begin n_bad++; $display("FAIL zero_latency: got %0d want 1", lat); end
    n_vec++; if ({io.sign_out, io.mantis_out, io.exp_out, io.type_number} !== {1'b1, 23'h0, 8'd0, 3'b001}) begin
      n_bad++; $display("FAIL zero_result: got s=%b m=%h e=%0d t=%b want s=1 m=0 e=0 t=001", io.sign_out, io.mantis_out, io.exp_out, io.type_number);
    end
    consume();
    send(1'b0, 27'h2000000, 1'b0, 10'd255, lat);
    n_vec++; if ({io.mantis_out, io.exp_out, io.type_number} !== {23'h0, 8'hFF, 3'b100}) begin
      n_bad++; $display("FAIL inf_result: got m=%h e=%0d t=%b want m=0 e=255 t=100", io.mantis_out, io.exp_out, io.type_number);
    end
    consume();
  endtask

  task automatic test_round();
    int lat;
    logic [22:0] exp_m;
    logic [33:0] want;
`ifdef FPA_ROUND_RNE_EN
    exp_m = 23'd2;
`else
    exp_m = 23'd1;
`endif
    send(1'b0, 27'h2000006, 1'b0, 10'd127, lat);
    n_vec++; if (io.mantis_out !== exp_m) begin n_bad++; $display("FAIL tie_odd: got m=%h want m=%h", io.mantis_out, exp_m); end
    consume();
    send(1'b0, 27'h2000002, 1'b0, 10'd127, lat);
    n_vec++; if (io.mantis_out !== 23'd0) begin n_bad++; $display("FAIL tie_even: got m=%h want m=0", io.mantis_out); end
    consume();
`ifdef FPA_ROUND_RNE_EN
    want = {23'h0, 8'hFF, 3'b100};
`else
    want = {23'h7FFFFF, 8'd254, 3'b011};
`endif
    send(1'b0, 27'h3FFFFFE, 1'b0, 10'd254, lat);
    n_vec++; if (lat !== 3) begin n_bad++; $display("FAIL rcarry_latency: got %0d want 3", lat); end
    n_vec++; if ({io.mantis_out, io.exp_out, io.type_number} !== want) begin
      n_bad++; $display("FAIL rcarry_result: got m=%h e=%0d t=%b want %h", io.mantis_out, io.exp_out, io.type_number, want);
    end
    consume();
  endtask

  task automatic test_backpressure();
    int lat;
    send(1'b0, 27'h4000000, 1'b0, 10'd127, lat);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_vec++; if ({io.out_valid, io.mantis_out, io.exp_out, io.type_number} !== {1'b1, 23'h0, 8'd128, 3'b011}) begin
        n_bad++; $display("FAIL hold_%0d: got v=%b m=%h e=%0d t=%b want v=1 m=0 e=128 t=011", i, io.out_valid, io.mantis_out, io.exp_out, io.type_number);
      end
    end
    consume();
    @(negedge clk);
    n_vec++; if ({io.out_valid, io.in_ready} !== 2'b01) begin
      n_bad++; $display("FAIL post_handshake: got v=%b rdy=%b want v=0 rdy=1", io.out_valid, io.in_ready);
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    int w;
    w = 0;
    @(negedge clk);
    while (!io.in_ready && w < 20) begin @(negedge clk); w++; end
    io.in_valid  = 1'b1;
    io.sign_in   = 1'b1;
    io.mantis_in = 27'h0000004;
    io.sticky_in = 1'b0;
    io.exp_in    = 10'd127;
    @(posedge clk);
    #1 io.in_valid = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    n_vec++; if ({io.out_valid, io.in_ready} !== 2'b00) begin
      n_bad++; $display("FAIL midrst_flags: got v=%b rdy=%b want v=0 rdy=0", io.out_valid, io.in_ready);
    end
    n_vec++; if ({io.sign_out, io.mantis_out, io.exp_out, io.type_number} !== 35'd0) begin
      n_bad++; $display("FAIL midrst_outputs: got s=%b m=%h e=%h t=%b want all 0", io.sign_out, io.mantis_out, io.exp_out, io.type_number);
    end
    @(negedge clk);
    n_vec++; if (io.in_ready !== 1'b1) begin n_bad++; $display("FAIL midrst_release: got %b want 1", io.in_ready); end
    send(1'b0, 27'h4000000, 1'b0, 10'd127, lat);
    n_vec++; if (lat !== 4) begin n_bad++; $display("FAIL midrst_latency: got %0d want 4", lat); end
    n_vec++; if ({io.mantis_out, io.exp_out, io.type_number} !== {23'h0, 8'd128, 3'b011}) begin
      n_bad++; $display("FAIL midrst_result: got m=%h e=%0d t=%b want m=0 e=128 t=011", io.mantis_out, io.exp_out, io.type_number);
    end
    consume();
  endtask

  initial begin
    io.in_valid  = 1'b0;
    io.sign_in   = 1'b0;
    io.mantis_in = '0;
    io.sticky_in = 1'b0;
    io.exp_in    = '0;
    io.out_ready = 1'b0;
    test_reset();
    test_normal();
    test_right_shift();
    test_left_shift();
    test_denorm_shift();
    test_zero_inf();
    test_round();
    test_backpressure();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
